// File: rtl/operand_collector.sv
// Serial-to-parallel operand collector: packs up to eight WIDTH-bit words into lanes a..h
// and holds the completed frame behind a valid/ready handshake.
module operand_collector #(
  parameter int unsigned       WIDTH = 8,
  parameter logic [WIDTH-1:0]  PAD   = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] h,
  output logic [3:0]       out_count,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic ST_FILL = 1'b0;
  localparam logic ST_FULL = 1'b1;

  logic             state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [3:0]       count_q, count_d;
  logic [WIDTH-1:0] lane_q [8];
  logic [WIDTH-1:0] lane_d [8];

  assign in_ready  = (state_q == ST_FILL);
  assign out_valid = (state_q == ST_FULL);
  assign out_count = count_q;

  assign a = lane_q[0];
  assign b = lane_q[1];
  assign c = lane_q[2];
  assign d = lane_q[3];
  assign e = lane_q[4];
  assign f = lane_q[5];
  assign g = lane_q[6];
  assign h = lane_q[7];

  // NOTE: every next-state variable gets its hold value first, so no path through this block can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    lane_d  = lane_q;
    case (state_q)
      ST_FILL: begin
        if (in_valid) begin
          lane_d[cnt_q] = in_data;
          if (cnt_q == 3'd7 || in_last) begin
            // Lanes past the last real word are padded on the same edge that closes the frame.
            for (int i = 0; i < 8; i++) begin
              if (i > int'(cnt_q)) lane_d[i] = PAD;
            end
            count_d = 4'(cnt_q) + 4'd1;
            cnt_d   = 3'd0;
            state_d = ST_FULL;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      default: begin
        if (out_ready) state_d = ST_FILL;
      end
    endcase
  end

  // NOTE: the lane storage is reset too, because a..h must read zero after reset rather than stale data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FILL;
      cnt_q   <= 3'd0;
      count_q <= 4'd0;
      for (int i = 0; i < 8; i++) lane_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep all registers updating from the same pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      lane_q  <= lane_d;
    end
  end

endmodule

// File: tb/tb_operand_collector.sv
// Self-checking bench for operand_collector: table-driven frames plus hand-written
// backpressure, reset-mid-fill and random-gap scoreboard sequences.
module tb_operand_collector;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic [7:0] a, b, c, d, e, f, g, h;
  logic [3:0] out_count;
  logic       out_valid;
  logic       out_ready;

  always #5 clk = ~clk;

  operand_collector #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .e         (e),
    .f         (f),
    .g         (g),
    .h         (h),
    .out_count (out_count),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  wire [7:0] lane [8];
  assign lane[0] = a;
  assign lane[1] = b;
  assign lane[2] = c;
  assign lane[3] = d;
  assign lane[4] = e;
  assign lane[5] = f;
  assign lane[6] = g;
  assign lane[7] = h;

  typedef struct {
    int         n;
    logic       last;
    logic [7:0] data [8];
    logic [7:0] exp  [8];
    logic [3:0] cnt;
  } vec_t;

  vec_t vecs [5];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Present one word from the falling edge until it is accepted at a rising edge.
  task automatic push(input logic [7:0] w, input logic last);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    in_last  = last;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("push_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic [7:0] exp [8], input logic [3:0] cnt);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_out_count"}, 32'(out_count), 32'(cnt));
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_lane%0d", tag, i), 32'(lane[i]), 32'(exp[i]));
  endtask

  task automatic release_frame(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_rel_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_rel_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [7:0] exp8 [8];
    logic [7:0] sb [$];
    int         frames;
    int         widx;
    logic       prev_valid;

    vecs[0].n = 8; vecs[0].last = 1'b0; vecs[0].cnt = 4'd8;
    vecs[0].data = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    vecs[0].exp  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    vecs[1].n = 3; vecs[1].last = 1'b1; vecs[1].cnt = 4'd3;
    vecs[1].data = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[1].exp  = '{8'h11, 8'h22, 8'h33, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    vecs[2].n = 1; vecs[2].last = 1'b1; vecs[2].cnt = 4'd1;
    vecs[2].data = '{8'h7E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[2].exp  = '{8'h7E, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    vecs[3].n = 8; vecs[3].last = 1'b1; vecs[3].cnt = 4'd8;
    vecs[3].data = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8};
    vecs[3].exp  = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8};
    vecs[4].n = 5; vecs[4].last = 1'b1; vecs[4].cnt = 4'd5;
    vecs[4].data = '{8'h3C, 8'h4D, 8'h5E, 8'h6F, 8'h70, 8'h00, 8'h00, 8'h00};
    vecs[4].exp  = '{8'h3C, 8'h4D, 8'h5E, 8'h6F, 8'h70, 8'hFF, 8'hFF, 8'hFF};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_count", 32'(out_count), 32'd0);
    for (int i = 0; i < 8; i++) check($sformatf("rst_lane%0d", i), 32'(lane[i]), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven frames: full, short, single-word, redundant last, five-word.
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < vecs[v].n; i++) begin
        push(vecs[v].data[i], vecs[v].last && (i == vecs[v].n - 1));
        if (i < vecs[v].n - 1)
          check($sformatf("vec%0d_w%0d_out_valid", v, i), 32'(out_valid), 32'd0);
      end
      check_frame($sformatf("vec%0d", v), vecs[v].exp, vecs[v].cnt);
      release_frame($sformatf("vec%0d", v));
    end

    // Backpressure: frame held five cycles while 0x55 waits upstream.
    for (int i = 0; i < 8; i++) push(8'(8'h21 + i), 1'b0);
    exp8 = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h55;
    in_last  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check_frame($sformatf("bp%0d", k), exp8, 4'd8);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_rel_in_ready", 32'(in_ready), 32'd1);
    check("bp_rel_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    exp8 = '{8'h55, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    check_frame("bp_next", exp8, 4'd1);
    release_frame("bp_next");

    // Reset mid-fill discards the partial frame.
    for (int i = 0; i < 4; i++) push(8'(8'hE0 + i), 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rmf_out_valid", 32'(out_valid), 32'd0);
    check("rmf_a", 32'(a), 32'd0);
    check("rmf_out_count", 32'(out_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push(8'(8'h0A + i), 1'b0);
      if (i < 7) check($sformatf("rmf_w%0d_out_valid", i), 32'(out_valid), 32'd0);
    end
    exp8 = '{8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10, 8'h11};
    check_frame("rmf", exp8, 4'd8);
    release_frame("rmf");

    // Random in_valid gaps, out_ready tied high, two frames checked against a scoreboard.
    frames     = 0;
    widx       = 0;
    prev_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 300 && frames < 2; cyc++) begin
      @(negedge clk);
      in_valid = (widx < 16) && ($urandom_range(1) == 1);
      in_data  = 8'(8'hC0 + widx);
      in_last  = 1'b0;
      if (in_valid && in_ready) begin
        sb.push_back(in_data);
        widx++;
      end
      @(posedge clk);
      #1;
      if (out_valid) begin
        if (prev_valid) check("gap_pulse_width", 32'(prev_valid), 32'd0);
        check("gap_sb_depth", 32'(sb.size()), 32'd8);
        check("gap_out_count", 32'(out_count), 32'd8);
        for (int i = 0; i < 8; i++) begin
          if (sb.size() > 0) check($sformatf("gap_f%0d_lane%0d", frames, i), 32'(lane[i]), 32'(sb.pop_front()));
        end
        frames++;
      end
      prev_valid = out_valid;
    end
    in_valid = 1'b0;
    check("gap_frames_seen", 32'(frames), 32'd2);
    check("gap_sb_empty", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
    check("gap_final_out_valid", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
